// File: rtl/online_mul_residual_datapath.sv
// Radix-2 online (MSD-first) signed-digit multiplier datapath, N digits per
// operand and result, online delay DELTA.
//
// Holds the operand prefixes X/Y, forms the selector term
// H = xd*Ynew + yd*Xold, and updates the residual V = 2W + H.
// In output steps it estimates the residual from its top three bits and
// selects the result digit.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         begin an operation (honoured only in IDLE)
//   in_vd, in_rd  input digit handshake for x/y ({plus,minus} encoding)
//   p             result digit {plus,minus}, never 11
//   out_vd,out_rd output digit handshake
//   done          one-cycle pulse after the last digit is accepted
//   residual      current residual W (debug)
module online_mul_residual_datapath #(
   parameter int N     = 4,
   parameter int DELTA = 3,
   parameter int RW    = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_vd,
   output logic          in_rd,
   input  logic [1:0]    x,
   input  logic [1:0]    y,
   output logic [1:0]    p,
   output logic          out_vd,
   input  logic          out_rd,
   output logic          done,
   output logic [RW-1:0] residual
);

   localparam int KW = $clog2(N + DELTA + 1);

   typedef enum logic [1:0] {IDLE, BUSY, LAST} state_t;
   state_t state, state_nx;

   logic [KW-1:0]        k;
   logic signed [RW-1:0] xp, yp, w;

   logic                 stall, in_phase, out_phase, step, last_step;
   logic [1:0]           xd, yd, pd;
   logic signed [RW-1:0] weight, x_new, y_new, h, v, w_next;
   logic signed [2:0]    est;

   // Signed-digit times value: +1 passes, -1 negates, 0 (00 or 11) clears.
   function automatic logic signed [RW-1:0] sel(input logic [1:0] d,
                                                input logic signed [RW-1:0] val);
      case (d)
         2'b10:   return val;
         2'b01:   return -val;
         default: return '0;
      endcase
   endfunction

   assign stall     = out_vd & ~out_rd;
   assign in_phase  = (k < KW'(N));
   assign out_phase = (k >= KW'(DELTA));
   assign last_step = (k == KW'(N + DELTA - 1));
   assign step      = (state == BUSY) & ~stall & (in_phase ? in_vd : 1'b1);

   // Past the operand length the pins are ignored and digits read as zero.
   assign xd = in_phase ? x : 2'b00;
   assign yd = in_phase ? y : 2'b00;

   always_comb begin
      weight = '0;
      if (in_phase)
         weight = RW'(1) <<< (KW'(N - 1) - k);
   end

   assign x_new = xp + sel(xd, weight);
   assign y_new = yp + sel(yd, weight);
   // Ynew includes the current y digit, Xold excludes the current x digit,
   // so the cross product x_{k+1}*y_{k+1} is counted exactly once.
   assign h     = sel(xd, y_new) + sel(yd, xp);
   assign v     = (w <<< 1) + h;
   assign est   = v[RW-1:RW-3];

   always_comb begin
      pd = 2'b00;
      if (est >= 3'sd1)
         pd = 2'b10;
      else if (est <= -3'sd2)
         pd = 2'b01;
   end

   always_comb begin
      w_next = v;
      if (out_phase) begin
         case (pd)
            2'b10:   w_next = v - (RW'(1) <<< (N + DELTA));
            2'b01:   w_next = v + (RW'(1) <<< (N + DELTA));
            default: w_next = v;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start)             state_nx = BUSY;
         BUSY:    if (step && last_step) state_nx = LAST;
         LAST:    if (out_vd && out_rd)  state_nx = IDLE;
         default:                        state_nx = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      in_rd = (state == BUSY) & in_phase & ~stall;
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         xp     <= '0;
         yp     <= '0;
         w      <= '0;
         k      <= '0;
         p      <= 2'b00;
         out_vd <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= (state == LAST) & out_vd & out_rd;
         if (state == IDLE && start) begin
            xp <= '0;
            yp <= '0;
            w  <= '0;
            k  <= '0;
         end else if (step) begin
            xp <= x_new;
            yp <= y_new;
            w  <= w_next;
            k  <= k + KW'(1);
         end
         // A fresh digit overrides the acceptance clear of the previous one.
         if (step && out_phase) begin
            p      <= pd;
            out_vd <= 1'b1;
         end else if (out_rd) begin
            out_vd <= 1'b0;
         end
      end
   end

   assign residual = w;

endmodule

// File: tb/tb_online_mul_residual_datapath.sv
// Scoreboard bench for online_mul_residual_datapath: the driver queues the
// hand-computed result digits of each operation, the monitor pops and
// compares them on every accepted output digit.
module tb_online_mul_residual_datapath;
   localparam int RW = 9;
   localparam logic [1:0] P = 2'b10, M = 2'b01, Z = 2'b00;

   logic          clk = 1'b0;
   logic          rst, start, in_vd, in_rd, out_vd, out_rd, done;
   logic [1:0]    x, y, p;
   logic [RW-1:0] residual;

   int errors = 0;
   int checks = 0;
   int acc_cnt = 0;
   int done_cnt = 0;
   logic bp = 1'b0;
   logic [1:0] q[$];

   online_mul_residual_datapath #(.N(4), .DELTA(3), .RW(RW)) dut (
      .clk(clk), .rst(rst), .start(start), .in_vd(in_vd), .in_rd(in_rd),
      .x(x), .y(y), .p(p), .out_vd(out_vd), .out_rd(out_rd), .done(done),
      .residual(residual)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int res_val();
      return int'($signed(residual));
   endfunction

   // Consumer: always ready, or in backpressure mode holds out_rd low for
   // three cycles on every presented digit before accepting it.
   initial begin
      int hold;
      hold = 0;
      out_rd = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (!bp) begin
            out_rd = 1'b1;
            hold = 0;
         end else if (!out_vd) begin
            out_rd = 1'b0;
            hold = 0;
         end else if (hold < 3) begin
            out_rd = 1'b0;
            hold++;
         end else begin
            out_rd = 1'b1;
            hold = 0;
         end
      end
   end

   // Monitor
   initial begin
      logic       held;
      logic [1:0] held_p;
      logic [1:0] e;
      held = 1'b0;
      held_p = 2'b00;
      forever begin
         @(negedge clk);
         if (rst) begin
            held = 1'b0;
         end else begin
            if (held) begin
               chk("hold_vd", int'(out_vd), 1);
               chk("hold_p", int'(p), int'(held_p));
            end
            if (out_vd && out_rd) begin
               if (q.size() == 0) begin
                  chk("p_unexpected", int'(p), -1);
               end else begin
                  e = q.pop_front();
                  chk("p_digit", int'(p), int'(e));
               end
               acc_cnt++;
            end
            if (out_vd && !out_rd) begin
               chk("in_rd_stall", int'(in_rd), 0);
               held = 1'b1;
               held_p = p;
            end else begin
               held = 1'b0;
            end
            if (done) begin
               chk("done_after_4", acc_cnt, 4);
               done_cnt++;
            end
         end
      end
   end

   task automatic run_op(input logic [7:0] xs, input logic [7:0] ys,
                         input logic [7:0] ep, input int r0, input int r1,
                         input int r2, input bit gaps, input bit bpm,
                         input bit mid_start);
      int rr[3];
      int prev;
      int n;
      rr[0] = r0; rr[1] = r1; rr[2] = r2;
      bp = bpm;
      acc_cnt = 0;
      done_cnt = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < 4; i++) q.push_back(ep[7-2*i -: 2]);
      for (int i = 0; i < 4; i++) begin
         if (gaps) begin
            prev = (i == 0) ? 0 : rr[i-1];
            in_vd = 1'b0;
            repeat (2) @(posedge clk);
            #1 chk("gap_hold", res_val(), prev);
         end
         x = xs[7-2*i -: 2];
         y = ys[7-2*i -: 2];
         in_vd = 1'b1;
         if (mid_start && i == 2) start = 1'b1;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!in_rd && n < 50);
         if (!in_rd) chk("in_rd_timeout", n, 0);
         @(posedge clk);
         #1;
         in_vd = 1'b0;
         start = 1'b0;
         x = 2'b00;
         y = 2'b00;
         if (i < 3) chk("residual_step", res_val(), rr[i]);
      end
      n = 0;
      while (done_cnt == 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", done_cnt, 1);
      repeat (3) @(negedge clk);
      chk("done_once", done_cnt, 1);
      chk("res_final", res_val(), 0);
      chk("queue_empty", q.size(), 0);
      bp = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; in_vd = 1'b0; x = 2'b00; y = 2'b00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_p", int'(p), 0);
      chk("rst_out_vd", int'(out_vd), 0);
      chk("rst_in_rd", int'(in_rd), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_residual", res_val(), 0);

      run_op({Z,Z,Z,Z}, {Z,Z,Z,Z}, {Z,Z,Z,Z}, 0, 0, 0, 0, 0, 0);
      run_op({P,Z,Z,Z}, {P,Z,Z,Z}, {P,M,Z,Z}, 8, 16, 32, 0, 0, 0);
      run_op({P,Z,Z,Z}, {M,Z,Z,Z}, {Z,M,Z,Z}, -8, -16, -32, 0, 0, 0);
      run_op({P,P,Z,Z}, {P,P,Z,Z}, {P,Z,P,M}, 8, 36, 72, 0, 0, 0);
      run_op({P,P,Z,Z}, {P,P,Z,Z}, {P,Z,P,M}, 8, 36, 72, 0, 1, 0);
      run_op({P,Z,Z,Z}, {P,Z,Z,Z}, {P,M,Z,Z}, 8, 16, 32, 1, 0, 0);
      run_op({P,P,Z,Z}, {P,P,Z,Z}, {P,Z,P,M}, 8, 36, 72, 0, 0, 1);

      // Reset in the middle of an operation
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         x = P; y = P; in_vd = 1'b1;
         @(posedge clk);
         #1;
      end
      in_vd = 1'b0; x = 2'b00; y = 2'b00;
      chk("mid_residual", res_val(), 36);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_residual", res_val(), 0);
      chk("midrst_out_vd", int'(out_vd), 0);
      chk("midrst_in_rd", int'(in_rd), 0);
      chk("midrst_p", int'(p), 0);
      chk("midrst_done", int'(done), 0);

      run_op({P,Z,Z,Z}, {M,Z,Z,Z}, {Z,M,Z,Z}, -8, -16, -32, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/online_mul_residual_datapath.md
Name: online_mul_residual_datapath

Overview:
- Radix-2 online (most-significant-digit-first) signed-digit multiplier datapath, N=4 digits, online delay 3.
- Combines four functions:
  - operand prefix registers
  - digit-vector selectors (prefix × digit)
  - residual adder/shifter
  - residual estimate (top-bit sample) with output-digit selection
- Sits between a digit-serial producer and a digit-serial consumer; uses valid/ready handshakes on both sides.

Parameters:
- N, 4: digits per operand and per result.
- DELTA, 3: online delay, i.e. steps before the first output digit.
- RW, 9: residual width, two's complement, units of 2^-(N+DELTA).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a new operation; honoured only in IDLE.
- in_vd  input  1  input digit pair valid.
- in_rd  output  1  block will consume x/y on this cycle.
- x  input  2  operand X digit, {plus,minus}: 10=+1, 01=-1, 00 or 11=0.
- y  input  2  operand Y digit, same encoding.
- p  output  2  result digit, {plus,minus}; never 11.
- out_vd  output  1  p valid.
- out_rd  input  1  consumer accepts p.
- done  output  1  one-cycle pulse after the last digit is accepted.
- residual  output  RW  current residual W (debug/verification).

Behaviour:
- Reset: p=00, out_vd=0, in_rd=0, done=0, residual=0, X=Y=0, step k=0, state IDLE.
- States:
  - IDLE: on start go to BUSY; clear X, Y and W, and set k=0.
  - BUSY: executes steps k = 0..N+DELTA-1.
  - After the last output digit is accepted: pulse done, return to IDLE.
  - start is ignored outside IDLE.
- Stall: stall = out_vd & ~out_rd. No step executes while stall is high; p and out_vd hold.
- in_rd = BUSY & (k<N) & ~stall.
- Step condition:
  - k<N: step fires when in_vd & in_rd; consumes digits x_{k+1}, y_{k+1}.
  - k>=N: step fires whenever ~stall; digits are treated as 0 and x/y pins are ignored.
- Prefix values (integers, units 2^-N):
  - X holds the digits received so far; digit i has weight 2^(N-i).
  - Y likewise.
  - Both update in the step cycle.
- Selector: H = xd·Ynew + yd·Xold.
  - xd, yd are the current digits in {-1,0,+1}.
  - Ynew includes the current y digit; Xold excludes the current x digit.
  - Digit +1 passes the prefix, -1 negates it, 0 gives 0.
- Adder: V = 2·W + H, computed in RW bits; no overflow is possible for legal digit inputs.
- Init steps (k<DELTA): W ← V; no output.
- Output steps (k>=DELTA):
  - Estimate E = V >>> (N+DELTA-1), i.e. the 3 MSBs, in range -4..3.
  - Select p = +1 if E>=1; p = -1 if E<=-2; otherwise p = 0.
  - Update W ← V − p·2^(N+DELTA).
  - p and out_vd are registered; they appear the cycle after the step.
  - out_vd clears on the cycle after out_rd acceptance unless a new step produces another digit.
- Latency: the first output digit is valid one cycle after step DELTA, which is the step consuming x4/y4 when there are no stalls.
- Accuracy: the output digit string P satisfies |P − X·Y| < 2^-N.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.

Test Plan:
- Reset, then start with X=Y=0 (all digits 00): p sequence 0,0,0,0; residual stays 0; done pulses once.
- X=Y=(+1,0,0,0), continuous valid, out_rd=1:
  - residual after steps 0..2 = 8, 16, 32
  - p = +1,-1,0,0 (value 0.25)
  - final residual 0.
- X=(+1,0,0,0), Y=(-1,0,0,0): residual -8,-16,-32, then p = 0,-1,0,0 (value -0.25).
- X=Y=(+1,+1,0,0):
  - residual after steps 0..2 = 8, 36, 72
  - p = +1,0,+1,-1 (value 0.5625)
  - residual after the last step is 0.
- Backpressure: the previous case with out_rd=0 for 3 cycles at each digit: p/out_vd hold, in_rd=0, same digit sequence, done only after the 4th acceptance.
- in_vd gaps during input steps stall the steps; rst asserted mid-op clears everything; start while BUSY is ignored.
